// File: rtl/debug_spi_pkg.sv
// Shared constants and FSM encoding for the debug SPI slave bridge.
// Frame layout, MSB first: {rw, addr[NB_ADDR-1:0], data[NB_DATA-1:0]}.
package debug_spi_pkg;

    localparam int NB_ADDR   = 7;
    localparam int NB_DATA   = 8;
    localparam int FRAME_LEN = 1 + NB_ADDR + NB_DATA;
    localparam int RW_BIT    = FRAME_LEN - 1;
    localparam int ADDR_LSB  = NB_DATA;
    localparam int DATA_LSB  = 0;
    localparam int CNT_W     = $clog2(FRAME_LEN + 1);

    // Only the most recent bits of a field need history; the final bit comes straight from MOSI.
    localparam int RX_W = (NB_ADDR > NB_DATA - 1) ? NB_ADDR : NB_DATA - 1;

    typedef enum logic [1:0] {
        WAIT_CS = 2'd0,
        IDLE    = 2'd1,
        CMD     = 2'd2,
        DATA    = 2'd3
    } spi_state_e;

endpackage

// File: rtl/spi_slave_bridge_if.sv
// Parallel register-access bus between the SPI bridge (master) and the debug register bank (slave).
interface spi_slave_bridge_if;
    import debug_spi_pkg::*;

    logic [NB_ADDR-1:0] spi_addr;
    logic [NB_DATA-1:0] spi_wdata;
    logic               spi_wr_en;
    logic [NB_DATA-1:0] spi_rdata;

    modport master (
        output spi_addr,
        output spi_wdata,
        output spi_wr_en,
        input  spi_rdata
    );

    modport slave (
        input  spi_addr,
        input  spi_wdata,
        input  spi_wr_en,
        output spi_rdata
    );

endinterface

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer for an asynchronous pin, plus a third flop that turns level changes
// into single-cycle rise/fall pulses in the clk domain.
module sync_edge_detect #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic rise,
    output logic fall
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
            prev_q <= RESET_VAL;
        end else begin
            meta_q <= async_in;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rise = sync_q & ~prev_q;
    assign fall = ~sync_q & prev_q;

endmodule

// File: rtl/spi_slave_bridge.sv
// SPI mode-0 slave that turns fixed-length frames into single-cycle register writes and
// returns the pre-write readback of the addressed register on MISO within the same frame.
module spi_slave_bridge (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      sclk,
    input  logic                      cs_n,
    input  logic                      mosi,
    output logic                      miso,
    output logic                      miso_oe,
    output logic                      frame_done,
    output logic                      frame_err,
    spi_slave_bridge_if.master        bus
);
    import debug_spi_pkg::*;

    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(NB_ADDR);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(FRAME_LEN);

    logic sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic cs_n_q, mosi_meta, mosi_sync;

    spi_state_e state_q, state_d;
    logic [CNT_W-1:0]   bit_cnt;
    logic [RX_W-1:0]    rx_shift;
    logic [NB_DATA-1:0] tx_shift;
    logic [NB_DATA-1:0] wdata_q;
    logic [NB_ADDR-1:0] addr_q;
    logic rw_q, load_tx_q, wr_en_q;
    logic start_frame, shift_bit, latch_addr, end_frame, abort;

    // cs_n resets low so a pin already high out of reset shows up as a rise, never a false fall.
    sync_edge_detect #(.RESET_VAL(1'b0)) u_sclk_sync (
        .clk(clk), .rst(rst), .async_in(sclk), .rise(sclk_rise), .fall(sclk_fall)
    );

    sync_edge_detect #(.RESET_VAL(1'b0)) u_cs_sync (
        .clk(clk), .rst(rst), .async_in(cs_n), .rise(cs_rise), .fall(cs_fall)
    );

    // MOSI shares the two-flop latency of the SCLK path, so it is valid when a rise is flagged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mosi_meta <= 1'b0;
            mosi_sync <= 1'b0;
            cs_n_q    <= 1'b0;
        end else begin
            mosi_meta <= mosi;
            mosi_sync <= mosi_meta;
            if (cs_rise) begin
                cs_n_q <= 1'b1;
            end else if (cs_fall) begin
                cs_n_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= WAIT_CS;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        start_frame = 1'b0;
        shift_bit   = 1'b0;
        latch_addr  = 1'b0;
        end_frame   = 1'b0;
        abort       = 1'b0;
        case (state_q)
            WAIT_CS: begin
                if (cs_n_q) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (cs_fall) begin
                    start_frame = 1'b1;
                    state_d     = CMD;
                end
            end
            CMD: begin
                if (cs_rise) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end else if (sclk_rise) begin
                    shift_bit = 1'b1;
                    if (bit_cnt == ADDR_LAST) begin
                        latch_addr = 1'b1;
                        state_d    = DATA;
                    end
                end
            end
            DATA: begin
                // The last rise wins over a simultaneous CS release: the frame is complete.
                if (sclk_rise && bit_cnt == DATA_LAST) begin
                    shift_bit = 1'b1;
                    end_frame = 1'b1;
                    state_d   = WAIT_CS;
                end else if (cs_rise) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end else if (sclk_rise) begin
                    shift_bit = 1'b1;
                end
            end
            default: state_d = WAIT_CS;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt    <= '0;
            rx_shift   <= '0;
            tx_shift   <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rw_q       <= 1'b0;
            load_tx_q  <= 1'b0;
            wr_en_q    <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            miso       <= 1'b0;
        end else begin
            load_tx_q  <= latch_addr;
            frame_done <= end_frame;
            frame_err  <= abort;
            wr_en_q    <= end_frame & rw_q;

            if (start_frame) begin
                bit_cnt  <= '0;
                rx_shift <= '0;
            end else if (shift_bit) begin
                bit_cnt  <= (bit_cnt == CNT_MAX) ? bit_cnt : bit_cnt + 1'b1;
                rx_shift <= {rx_shift[RX_W-2:0], mosi_sync};
            end

            if (latch_addr) begin
                addr_q <= {rx_shift[NB_ADDR-2:0], mosi_sync};
                rw_q   <= rx_shift[NB_ADDR-1];
            end

            if (end_frame && rw_q) begin
                wdata_q <= {rx_shift[NB_DATA-2:0], mosi_sync};
            end

            // spi_rdata already reflects the freshly latched address by the load cycle.
            if (load_tx_q) begin
                tx_shift <= bus.spi_rdata;
            end else if (state_q == DATA && sclk_fall) begin
                tx_shift <= {tx_shift[NB_DATA-2:0], 1'b0};
            end

            if (state_q != DATA) begin
                miso <= 1'b0;
            end else if (sclk_fall) begin
                miso <= tx_shift[NB_DATA-1];
            end
        end
    end

    assign miso_oe       = ~cs_n_q && (state_q != WAIT_CS);
    assign bus.spi_addr  = addr_q;
    assign bus.spi_wdata = wdata_q;
    assign bus.spi_wr_en = wr_en_q;

endmodule

// File: tb/tb_spi_slave_bridge.sv
// Directed bench for spi_slave_bridge: a mode-0 SPI master, a small register bank on the
// parallel bus, and hand-computed expectations for each frame.
module tb_spi_slave_bridge;

    logic clk;
    logic rst;
    logic sclk;
    logic cs_n;
    logic mosi;
    logic miso;
    logic miso_oe;
    logic frame_done;
    logic frame_err;

    spi_slave_bridge_if bus ();

    spi_slave_bridge dut (
        .clk        (clk),
        .rst        (rst),
        .sclk       (sclk),
        .cs_n       (cs_n),
        .mosi       (mosi),
        .miso       (miso),
        .miso_oe    (miso_oe),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] bank [0:127];
    int wr_count;
    int done_count;
    int err_count;
    logic [6:0] last_wr_addr;
    logic [7:0] last_wr_data;

    assign bus.spi_rdata = bank[bus.spi_addr];

    // Register bank plus pulse counters; counting edges also proves each pulse is one cycle wide.
    always @(posedge clk) begin
        if (bus.spi_wr_en) begin
            bank[bus.spi_addr] <= bus.spi_wdata;
            wr_count     <= wr_count + 1;
            last_wr_addr <= bus.spi_addr;
            last_wr_data <= bus.spi_wdata;
        end
        if (frame_done) done_count <= done_count + 1;
        if (frame_err)  err_count  <= err_count + 1;
    end

    int vectors;
    int miscompares;

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Half SCLK period is 8 clk; MISO is sampled on each rise as a mode-0 master would.
    task automatic apply_stimulus(input logic [15:0] word, input int nbits, input bit raise_cs,
                                  input int gap, output logic [15:0] rx_word,
                                  output logic extra_or, output logic oe_seen);
        rx_word  = '0;
        extra_or = 1'b0;
        oe_seen  = 1'b0;
        cs_n = 1'b0;
        wait_clk(8);
        for (int i = 0; i < nbits; i++) begin
            mosi = (i < 16) ? word[15 - i] : 1'b0;
            wait_clk(8);
            sclk = 1'b1;
            if (i < 16) rx_word[15 - i] = miso;
            else        extra_or = extra_or | miso;
            if (i == 0) oe_seen = miso_oe;
            wait_clk(8);
            sclk = 1'b0;
        end
        wait_clk(8);
        if (raise_cs) begin
            cs_n = 1'b1;
            wait_clk(gap);
        end
    endtask

    initial begin
        logic [15:0] rx_word;
        logic extra;
        logic oe;
        int wr0, done0, err0;

        vectors      = 0;
        miscompares  = 0;
        wr_count     = 0;
        done_count   = 0;
        err_count    = 0;
        last_wr_addr = '0;
        last_wr_data = '0;
        for (int a = 0; a < 128; a++) bank[a] = 8'h00;
        bank[7'h10] = 8'h5A;
        bank[7'h11] = 8'hFF;
        bank[7'h20] = 8'h3C;
        bank[7'h30] = 8'h81;

        rst  = 1'b1;
        cs_n = 1'b1;
        sclk = 1'b0;
        mosi = 1'b0;
        wait_clk(3);
        check_output("rst_miso",     32'(miso),          32'd0);
        check_output("rst_miso_oe",  32'(miso_oe),       32'd0);
        check_output("rst_addr",     32'(bus.spi_addr),  32'd0);
        check_output("rst_wr_en",    32'(bus.spi_wr_en), 32'd0);
        check_output("rst_done",     32'(frame_done),    32'd0);
        check_output("rst_err",      32'(frame_err),     32'd0);
        rst = 1'b0;
        wait_clk(10);
        check_output("idle_miso_oe", 32'(miso_oe),       32'd0);

        $display("[TB] write frame 0x90A5");
        wr0 = wr_count; done0 = done_count; err0 = err_count;
        apply_stimulus(16'h90A5, 16, 1'b1, 8, rx_word, extra, oe);
        check_output("w1_wr_cnt",    32'(wr_count - wr0),     32'd1);
        check_output("w1_addr",      32'(last_wr_addr),       32'h10);
        check_output("w1_data",      32'(last_wr_data),       32'hA5);
        check_output("w1_done_cnt",  32'(done_count - done0), 32'd1);
        check_output("w1_err_cnt",   32'(err_count - err0),   32'd0);
        check_output("w1_miso_data", 32'(rx_word[7:0]),       32'h5A);
        check_output("w1_miso_cmd",  32'(rx_word[15:8]),      32'h00);
        check_output("w1_miso_oe",   32'(oe),                 32'd1);

        $display("[TB] read frame 0x2000");
        wr0 = wr_count; done0 = done_count;
        apply_stimulus(16'h2000, 16, 1'b1, 8, rx_word, extra, oe);
        check_output("r1_miso_data", 32'(rx_word[7:0]),       32'h3C);
        check_output("r1_miso_cmd",  32'(rx_word[15:8]),      32'h00);
        check_output("r1_wr_cnt",    32'(wr_count - wr0),     32'd0);
        check_output("r1_addr",      32'(bus.spi_addr),       32'h20);
        check_output("r1_done_cnt",  32'(done_count - done0), 32'd1);

        $display("[TB] aborted write to 0x30, then full write 0xB055");
        wr0 = wr_count; done0 = done_count; err0 = err_count;
        apply_stimulus(16'hB077, 10, 1'b1, 8, rx_word, extra, oe);
        check_output("ab_err_cnt",   32'(err_count - err0),   32'd1);
        check_output("ab_wr_cnt",    32'(wr_count - wr0),     32'd0);
        check_output("ab_done_cnt",  32'(done_count - done0), 32'd0);
        wr0 = wr_count; err0 = err_count;
        apply_stimulus(16'hB055, 16, 1'b1, 8, rx_word, extra, oe);
        check_output("w2_wr_cnt",    32'(wr_count - wr0),     32'd1);
        check_output("w2_addr",      32'(last_wr_addr),       32'h30);
        check_output("w2_data",      32'(last_wr_data),       32'h55);
        check_output("w2_miso_data", 32'(rx_word[7:0]),       32'h81);
        check_output("w2_err_cnt",   32'(err_count - err0),   32'd0);

        $display("[TB] overlong write 0x9101 with 20 SCLKs");
        wr0 = wr_count; done0 = done_count;
        apply_stimulus(16'h9101, 20, 1'b1, 8, rx_word, extra, oe);
        check_output("ol_wr_cnt",    32'(wr_count - wr0),     32'd1);
        check_output("ol_addr",      32'(last_wr_addr),       32'h11);
        check_output("ol_data",      32'(last_wr_data),       32'h01);
        check_output("ol_miso_data", 32'(rx_word[7:0]),       32'hFF);
        check_output("ol_miso_tail", 32'(extra),              32'd0);
        check_output("ol_done_cnt",  32'(done_count - done0), 32'd1);

        $display("[TB] reset in the middle of a write frame");
        wr0 = wr_count; done0 = done_count; err0 = err_count;
        apply_stimulus(16'h95AA, 5, 1'b0, 0, rx_word, extra, oe);
        rst = 1'b1;
        wait_clk(2);
        check_output("mr_miso",      32'(miso),          32'd0);
        check_output("mr_miso_oe",   32'(miso_oe),       32'd0);
        check_output("mr_addr",      32'(bus.spi_addr),  32'd0);
        check_output("mr_wr_en",     32'(bus.spi_wr_en), 32'd0);
        check_output("mr_done",      32'(frame_done),    32'd0);
        check_output("mr_err",       32'(frame_err),     32'd0);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            mosi = 1'b1;
            wait_clk(8);
            sclk = 1'b1;
            wait_clk(8);
            sclk = 1'b0;
        end
        wait_clk(8);
        check_output("mr_oe_held",   32'(miso_oe),            32'd0);
        check_output("mr_wr_none",   32'(wr_count - wr0),     32'd0);
        check_output("mr_done_none", 32'(done_count - done0), 32'd0);
        cs_n = 1'b1;
        wait_clk(8);
        apply_stimulus(16'h9566, 16, 1'b1, 8, rx_word, extra, oe);
        check_output("mr_wr_cnt",    32'(wr_count - wr0),     32'd1);
        check_output("mr_wr_addr",   32'(last_wr_addr),       32'h15);
        check_output("mr_wr_data",   32'(last_wr_data),       32'h66);
        check_output("mr_err_cnt",   32'(err_count - err0),   32'd0);

        $display("[TB] back-to-back writes with a 4 clk CS gap");
        wr0 = wr_count; err0 = err_count;
        apply_stimulus(16'h9301, 16, 1'b1, 4, rx_word, extra, oe);
        check_output("bb1_addr",     32'(last_wr_addr),       32'h13);
        check_output("bb1_data",     32'(last_wr_data),       32'h01);
        apply_stimulus(16'h9402, 16, 1'b1, 8, rx_word, extra, oe);
        check_output("bb2_addr",     32'(last_wr_addr),       32'h14);
        check_output("bb2_data",     32'(last_wr_data),       32'h02);
        check_output("bb_wr_cnt",    32'(wr_count - wr0),     32'd2);
        check_output("bb_err_cnt",   32'(err_count - err0),   32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/spi_slave_bridge.md
# spi_slave_bridge

Serial-to-parallel front end that terminates the external debug SPI link and drives the parallel register-access bus of the debug register bank (`spi_addr`, `spi_wdata`, `spi_wr_en`, `spi_rdata`). It oversamples SCLK, CS_N and MOSI in the system clock domain and decodes fixed-length frames into single-cycle register writes. It also returns readback data on MISO in the same frame. Mode 0 only (CPOL=0, CPHA=0), MSB first.

## Interface
- NB_ADDR, 7, register address width
- NB_DATA, 8, register data width
- clk  in  1  system clock; SCLK ≤ clk/8
- rst  in  1  asynchronous, active-high reset
- sclk  in  1  SPI serial clock, asynchronous to clk
- cs_n  in  1  SPI chip select, active low, asynchronous
- mosi  in  1  SPI serial data in
- miso  out  1  SPI serial data out
- miso_oe  out  1  MISO output enable; high while synchronized cs_n is low and the FSM is not in WAIT_CS
- spi_addr  out  NB_ADDR  register address; held until the next frame's address is complete
- spi_wdata  out  NB_DATA  write data, valid while spi_wr_en is high
- spi_wr_en  out  1  one-cycle write strobe
- spi_rdata  in  NB_DATA  combinational readback of the register at spi_addr
- frame_done  out  1  one-cycle pulse on completion of a full frame
- frame_err  out  1  one-cycle pulse when CS_N deasserts mid-frame

## Operation
- Frame: FRAME_LEN = 1+NB_ADDR+NB_DATA bits (16 by default).
  - Bit 15 is R/W (1 = write).
  - Bits 14:8 are the address.
  - Bits 7:0 are the data.
- MOSI is sampled on each detected SCLK rise. MISO updates on each detected SCLK fall.
- FSM states:
  - WAIT_CS: reset state. Go to IDLE when synchronized cs_n = 1.
  - IDLE: a cs_n falling edge clears the bit counter and the RX shift register, then goes to CMD.
  - CMD: shift in R/W and the address. On the NB_ADDR+1-th rise: latch spi_addr and the R/W flag, then go to DATA.
  - DATA:
    - The cycle after entering DATA, load the TX shift register from spi_rdata.
    - On each fall, MISO takes the next TX bit, MSB first.
    - On the FRAME_LEN-th rise: go to WAIT_CS. The next cycle, pulse frame_done, and pulse spi_wr_en with spi_wdata = received byte if R/W = 1.
  - Any state except WAIT_CS/IDLE: cs_n rising edge → pulse frame_err, no write, go to IDLE.
- Full duplex: MISO returns the pre-write readback of spi_addr for both reads and writes.
- MISO is 0 during CMD, in WAIT_CS, and for any extra SCLK edges after FRAME_LEN. Extra edges are ignored, so there is never a second write.
- Bit counter: ceil(log2(FRAME_LEN+1)) bits, saturating at FRAME_LEN with no wrap.

## Timing
- Synchronizer: 2 flops plus an edge-detect flop. A pin edge is detected 3 clk cycles after it occurs (±1 cycle of sampling uncertainty).
- spi_wr_en is asserted exactly 1 clk after detection of the last SCLK rise. It is high for exactly 1 cycle, and spi_addr/spi_wdata are stable during it.
- TX load happens 1 clk after address latch. This is guaranteed to precede the first DATA-phase fall detection because SCLK half-period ≥ 4 clk.
- frame_err is asserted 1 clk after detection of the cs_n rise.
- Minimum cs_n high time between frames: 4 clk.
- Reset values:
  - All outputs 0; miso_oe 0.
  - FSM in WAIT_CS.
  - Synchronizer stages reset to sclk = 0, cs_n = 0, mosi = 0. The cs_n reset value of 0 prevents a false CS falling edge out of reset.
- Reset mid-frame: the in-progress frame is discarded with no write. The block waits in WAIT_CS for cs_n high.
- A cs_n rise in the same cycle as the last SCLK rise detection: the frame completes; no frame_err.

## Structure
- Package `debug_spi_pkg`:
  - FRAME_LEN, RW_BIT position, address/data field offsets.
  - FSM state typedef/encoding: WAIT_CS, IDLE, CMD, DATA.
- Sub-module `sync_edge_detect`: 2-flop synchronizer plus rise/fall pulse outputs, parameterized reset value. Instantiated for sclk and cs_n. MOSI uses the synchronizer only.

## Test plan
- Write frame 0x90A5 → spi_addr = 0x10, spi_wdata = 0xA5, exactly one spi_wr_en pulse, one frame_done, frame_err = 0.
- Read frame 0x2000, bank model returns 0x3C at 0x20 → MISO bits during DATA are 0,0,1,1,1,1,0,0; no spi_wr_en; spi_addr = 0x20 after the frame.
- Abort: cs_n high after 10 SCLK rises of a write to 0x30 → no spi_wr_en, one frame_err pulse; the following write frame 0xB055 writes 0x55 to 0x30.
- Overlong write frame 0x9101 with 20 SCLKs → exactly one spi_wr_en (addr 0x11, data 0x01); MISO = 0 after bit 16.
- rst pulsed mid-frame with cs_n low → all outputs 0, no write, and no frame starts until cs_n goes high and low again; the next frame completes normally.
- Back-to-back writes 0x9301 and 0x9402 with 4-clk cs_n gap → two spi_wr_en pulses, addresses 0x13 then 0x14.
